// File: rtl/elev_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elev_pkg
//  Description : Shared declarations for the elevator controller: the car
//                state enumeration and the bit width of the travel and door
//                countdown timers.
//  Revision    : 1.0  initial release
// ============================================================================
package elev_pkg;

    // Timer width; comfortably covers any practical TRAVEL_CYC / DOOR_CYC.
    localparam int unsigned c_tmr_w = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } elev_state_t;

endpackage : elev_pkg
`default_nettype wire

// File: rtl/elev_timer.sv
`default_nettype none
// ============================================================================
//  Module      : elev_timer
//  Description : Loadable down-counter. i_load (priority) loads i_load_val;
//                otherwise i_en decrements while non-zero. o_expire is high
//                during the enabled cycle in which the count is 1, so a load
//                of N expires after exactly N enabled cycles.
//  Ports       : clk, rst (sync, active-high), i_load, i_load_val[TMR_W],
//                i_en, o_expire
//  Revision    : 1.0  initial release
// ============================================================================
module elev_timer
    import elev_pkg::*;
#(
    parameter int TMR_W = c_tmr_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expire
);

    localparam logic [TMR_W-1:0] c_one = TMR_W'(1);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_expire = i_en && (r_count == c_one);

endmodule : elev_timer
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_ctrl
//  Description : Single-car elevator controller (IDLE / MOVING / DOOR_OPEN).
//                Latches floor calls, sweeps in one direction while requests
//                remain ahead, reverses otherwise, and opens the door at each
//                requested floor for DOOR_CYC cycles.
//  Ports       : clk, emergency (sync active-high reset), call_req[FLOORS],
//                overload (only with ELEV_OVERLOAD_EN), floor, dir_up,
//                moving, door_open, pending[FLOORS], arrived
//  Options     : ELEV_OVERLOAD_EN - adds the overload input, which holds the
//                door open and freezes the door timer while high.
//  Revision    : 1.0  initial release
// ============================================================================
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int FLOORS     = 4,
    parameter int TRAVEL_CYC = 8,
    parameter int DOOR_CYC   = 6
) (
    input  logic                      clk,
    input  logic                      emergency,
    input  logic [FLOORS-1:0]         call_req,
`ifdef ELEV_OVERLOAD_EN
    input  logic                      overload,
`endif
    output logic [$clog2(FLOORS)-1:0] floor,
    output logic                      dir_up,
    output logic                      moving,
    output logic                      door_open,
    output logic [FLOORS-1:0]         pending,
    output logic                      arrived
);

    localparam int                     c_floor_w   = $clog2(FLOORS);
    localparam logic [c_floor_w-1:0]   c_top_floor = c_floor_w'(FLOORS - 1);
    localparam logic [c_floor_w-1:0]   c_floor_one = c_floor_w'(1);
    localparam logic [c_tmr_w-1:0]     c_travel_ld = c_tmr_w'(TRAVEL_CYC);
    localparam logic [c_tmr_w-1:0]     c_door_ld   = c_tmr_w'(DOOR_CYC);

    elev_state_t          r_state, w_state_nxt;
    logic [c_floor_w-1:0] r_floor, w_floor_nxt, w_step_floor;
    logic                 r_dir_up, w_dir_nxt;
    logic [FLOORS-1:0]    r_pending, w_pend_nxt;
    logic                 r_arrived, w_arrived_nxt;

    logic w_trav_load, w_trav_en, w_trav_exp;
    logic w_door_load, w_door_en, w_door_exp, w_door_hold;
    logic w_can_step;
    logic w_above_cur, w_below_cur, w_above_step, w_below_step;

    // Any latched request strictly above / below a floor position.
    function automatic logic f_any_above(input logic [FLOORS-1:0]    p,
                                         input logic [c_floor_w-1:0] pos);
        f_any_above = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if ((i > int'(pos)) && p[i]) f_any_above = 1'b1;
        end
    endfunction

    function automatic logic f_any_below(input logic [FLOORS-1:0]    p,
                                         input logic [c_floor_w-1:0] pos);
        f_any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if ((i < int'(pos)) && p[i]) f_any_below = 1'b1;
        end
    endfunction

`ifdef ELEV_OVERLOAD_EN
    assign w_door_hold = overload;
`else
    assign w_door_hold = 1'b0;
`endif

    // Neighbouring floor in the travel direction; only used when w_can_step,
    // so the wrap at either end never reaches the floor register.
    assign w_can_step   = r_dir_up ? (r_floor != c_top_floor) : (r_floor != '0);
    assign w_step_floor = r_dir_up ? (r_floor + c_floor_one) : (r_floor - c_floor_one);

    assign w_above_cur  = f_any_above(r_pending, r_floor);
    assign w_below_cur  = f_any_below(r_pending, r_floor);
    assign w_above_step = f_any_above(r_pending, w_step_floor);
    assign w_below_step = f_any_below(r_pending, w_step_floor);

    assign w_trav_en = (r_state == MOVING);
    assign w_door_en = (r_state == DOOR_OPEN) && !w_door_hold;

    elev_timer #(.TMR_W(c_tmr_w)) u_travel_tmr (
        .clk        (clk),
        .rst        (emergency),
        .i_load     (w_trav_load),
        .i_load_val (c_travel_ld),
        .i_en       (w_trav_en),
        .o_expire   (w_trav_exp)
    );

    elev_timer #(.TMR_W(c_tmr_w)) u_door_tmr (
        .clk        (clk),
        .rst        (emergency),
        .i_load     (w_door_load),
        .i_load_val (c_door_ld),
        .i_en       (w_door_en),
        .o_expire   (w_door_exp)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_floor_nxt   = r_floor;
        w_dir_nxt     = r_dir_up;
        w_arrived_nxt = 1'b0;
        w_trav_load   = 1'b0;
        w_door_load   = 1'b0;
        w_pend_nxt    = r_pending | call_req;

        case (r_state)
            IDLE: begin
                if (r_pending[r_floor]) begin
                    w_state_nxt            = DOOR_OPEN;
                    w_door_load            = 1'b1;
                    w_pend_nxt[r_floor]    = 1'b0;
                end else if (r_dir_up ? w_above_cur : w_below_cur) begin
                    w_state_nxt = MOVING;
                    w_trav_load = 1'b1;
                end else if (r_dir_up ? w_below_cur : w_above_cur) begin
                    // Nothing ahead but something behind: reverse and go.
                    w_dir_nxt   = ~r_dir_up;
                    w_state_nxt = MOVING;
                    w_trav_load = 1'b1;
                end
            end

            MOVING: begin
                if (w_trav_exp) begin
                    if (!w_can_step) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_floor_nxt   = w_step_floor;
                        w_arrived_nxt = 1'b1;
                        if (r_pending[w_step_floor]) begin
                            w_state_nxt              = DOOR_OPEN;
                            w_door_load              = 1'b1;
                            w_pend_nxt[w_step_floor] = 1'b0;
                        end else if (r_dir_up ? w_above_step : w_below_step) begin
                            w_trav_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end

            DOOR_OPEN: begin
                // A call for the open floor is absorbed as a door-restart.
                w_pend_nxt[r_floor] = r_pending[r_floor];
                if (call_req[r_floor]) begin
                    w_door_load = 1'b1;
                end else if (w_door_exp) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (emergency) begin
            r_state   <= IDLE;
            r_floor   <= '0;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
            r_arrived <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_floor   <= w_floor_nxt;
            r_dir_up  <= w_dir_nxt;
            r_pending <= w_pend_nxt;
            r_arrived <= w_arrived_nxt;
        end
    end

    assign floor     = r_floor;
    assign dir_up    = r_dir_up;
    assign moving    = (r_state == MOVING);
    assign door_open = (r_state == DOOR_OPEN);
    assign pending   = r_pending;
    assign arrived   = r_arrived;

endmodule : elevator_ctrl
`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_ctrl
//  Description : Self-checking bench for elevator_ctrl (FLOORS=4, TRAVEL=8,
//                DOOR=6). A behavioural model tracks the car each cycle;
//                directed scenarios add fixed-timing checks, then random calls,
//                emergencies and (with ELEV_OVERLOAD_EN) overload follow.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_elevator_ctrl;

    localparam int FLOORS = 4;
    localparam int TRAVEL = 8;
    localparam int DOOR   = 6;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic              clk;
    logic              emergency;
    logic [FLOORS-1:0] call_req;
`ifdef ELEV_OVERLOAD_EN
    logic              overload;
`endif
    logic [1:0]        floor;
    logic              dir_up, moving, door_open, arrived;
    logic [FLOORS-1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int                m_floor;
    bit                m_up;
    int                m_mode;
    int                m_cnt;
    logic [FLOORS-1:0] m_pend;
    bit                m_arr;
    bit                m_valid = 1'b0;

    elevator_ctrl #(
        .FLOORS     (FLOORS),
        .TRAVEL_CYC (TRAVEL),
        .DOOR_CYC   (DOOR)
    ) dut (
        .clk       (clk),
        .emergency (emergency),
        .call_req  (call_req),
`ifdef ELEV_OVERLOAD_EN
        .overload  (overload),
`endif
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending),
        .arrived   (arrived)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit req_ahead(input logic [FLOORS-1:0] p, input int f, input bit up);
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock edge of the car as described by its rules.
    task automatic model_step();
        logic [FLOORS-1:0] nxt;
        bit frozen;
`ifdef ELEV_OVERLOAD_EN
        frozen = overload;
`else
        frozen = 1'b0;
`endif
        if (emergency) begin
            m_floor = 0; m_up = 1'b1; m_mode = M_IDLE; m_cnt = 0;
            m_pend = '0; m_arr = 1'b0; m_valid = 1'b1;
            return;
        end
        m_arr = 1'b0;
        nxt   = m_pend | call_req;
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_mode = M_DOOR; m_cnt = DOOR; nxt[m_floor] = 1'b0;
                end else if (req_ahead(m_pend, m_floor, m_up)) begin
                    m_mode = M_MOVE; m_cnt = TRAVEL;
                end else if (req_ahead(m_pend, m_floor, !m_up)) begin
                    m_up = !m_up; m_mode = M_MOVE; m_cnt = TRAVEL;
                end
            end
            M_MOVE: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_floor += m_up ? 1 : -1;
                    m_arr = 1'b1;
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR; m_cnt = DOOR; nxt[m_floor] = 1'b0;
                    end else if (req_ahead(m_pend, m_floor, m_up)) begin
                        m_cnt = TRAVEL;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_DOOR: begin
                nxt[m_floor] = m_pend[m_floor];
                if (call_req[m_floor]) begin
                    m_cnt = DOOR;
                end else if (!frozen) begin
                    m_cnt--;
                    if (m_cnt == 0) m_mode = M_IDLE;
                end
            end
            default: ;
        endcase
        m_pend = nxt;
    endtask

    task automatic cmp_model();
        if (!m_valid) return;
        chk("m_floor",   32'(floor),     32'(m_floor));
        chk("m_dir_up",  32'(dir_up),    32'(m_up));
        chk("m_moving",  32'(moving),    32'(m_mode == M_MOVE));
        chk("m_door",    32'(door_open), 32'(m_mode == M_DOOR));
        chk("m_pending", 32'(pending),   32'(m_pend));
        chk("m_arrived", 32'(arrived),   32'(m_arr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        emergency = 1'b1;
        call_req  = '0;
        tick();
        tick();
        emergency = 1'b0;
    endtask

    initial begin
        int dc, rem, narr, nd;
        bit mv, ho, prev_door;
        logic [31:0] order;

        emergency = 1'b1;
        call_req  = '0;
`ifdef ELEV_OVERLOAD_EN
        overload  = 1'b0;
`endif

        // ---- reset state, then single call to floor 2 from floor 0
        do_reset();
        chk("rst_floor",   32'(floor),     32'd0);
        chk("rst_dir_up",  32'(dir_up),    32'd1);
        chk("rst_pending", 32'(pending),   32'd0);
        chk("rst_moving",  32'(moving),    32'd0);
        chk("rst_door",    32'(door_open), 32'd0);
        chk("rst_arrived", 32'(arrived),   32'd0);

        call_req = 4'b0100; tick(); call_req = '0;          // t+1
        chk("A_pend_t1",   32'(pending), 32'h4);
        chk("A_idle_t1",   32'(moving),  32'd0);
        tick();                                              // t+2
        chk("A_move_t2",   32'(moving),  32'd1);
        repeat (8) tick();                                   // t+10
        chk("A_floor_t10", 32'(floor),   32'd1);
        chk("A_arr_t10",   32'(arrived), 32'd1);
        repeat (8) tick();                                   // t+18
        chk("A_floor_t18", 32'(floor),     32'd2);
        chk("A_door_t18",  32'(door_open), 32'd1);
        chk("A_pend_t18",  32'(pending),   32'd0);
        repeat (5) tick();                                   // t+23
        chk("A_door_t23",  32'(door_open), 32'd1);
        tick();                                              // t+24
        chk("A_door_t24",  32'(door_open), 32'd0);

        // ---- call for current floor while idle at 2
        call_req = 4'b0100; tick(); call_req = '0;
        chk("B_pend",   32'(pending),   32'h4);
        tick();
        chk("B_open",   32'(door_open), 32'd1);
        chk("B_pend0",  32'(pending),   32'd0);
        dc = 1; mv = 1'b0;
        for (int k = 0; k < 20 && door_open; k++) begin
            tick();
            if (door_open) dc++;
            if (moving || floor != 2'd2) mv = 1'b1;
        end
        chk("B_door_cycles", 32'(dc), 32'(DOOR));
        chk("B_no_move",     32'(mv), 32'd0);

        // ---- moving up to 3, call behind at floor 0
        do_reset();
        call_req = 4'b1000; tick(); call_req = '0;
        for (int k = 0; k < 100 && floor != 2'd1; k++) tick();
        chk("C_at1_moving", 32'(moving && dir_up), 32'd1);
        call_req = 4'b0001; tick(); call_req = '0;
        for (int k = 0; k < 200 && !door_open; k++) tick();
        chk("C_first_stop", 32'(floor), 32'd3);
        for (int k = 0; k < 50 && !moving; k++) tick();
        chk("C_reverse_dir", 32'(dir_up), 32'd0);
        for (int k = 0; k < 200 && !door_open; k++) tick();
        chk("C_second_stop", 32'(floor), 32'd0);

        // ---- all floors at once from floor 0
        do_reset();
        call_req = 4'b1111; tick(); call_req = '0;
        narr = 0; nd = 0; order = '0; prev_door = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (arrived) narr++;
            if (door_open && !prev_door) begin
                order = (order << 4) | 32'(floor);
                nd++;
            end
            prev_door = door_open;
            if (!moving && !door_open && pending == '0) break;
        end
        chk("D_order",    order,      32'h0123);
        chk("D_doors",    32'(nd),    32'd4);
        chk("D_arrivals", 32'(narr),  32'd3);

        // ---- emergency mid-travel between floors 2 and 3
        do_reset();
        call_req = 4'b1000; tick(); call_req = '0;
        for (int k = 0; k < 100 && !(floor == 2'd2 && moving); k++) tick();
        chk("E_reach2", 32'(floor == 2'd2 && moving), 32'd1);
        repeat (3) tick();
        emergency = 1'b1; call_req = 4'b0110;
        tick();
        chk("E_floor",   32'(floor),     32'd0);
        chk("E_pending", 32'(pending),   32'd0);
        chk("E_moving",  32'(moving),    32'd0);
        chk("E_door",    32'(door_open), 32'd0);
        chk("E_dir_up",  32'(dir_up),    32'd1);
        tick();
        emergency = 1'b0; call_req = '0;
        tick();
        chk("E_no_latch", 32'(pending), 32'd0);
        chk("E_still",    32'(moving),  32'd0);

`ifdef ELEV_OVERLOAD_EN
        // ---- overload during door open
        do_reset();
        call_req = 4'b0001; tick(); call_req = '0;
        tick();
        chk("F_open", 32'(door_open), 32'd1);
        tick();                                   // one door cycle consumed
        overload = 1'b1; ho = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!door_open) ho = 1'b0;
        end
        chk("F_held", 32'(ho), 32'd1);
        overload = 1'b0; rem = 0;
        for (int k = 0; k < 20 && door_open; k++) begin
            tick();
            rem++;
        end
        chk("F_remaining", 32'(rem), 32'(DOOR - 1));
`else
        ho = 1'b0; rem = 0;
`endif

        // ---- randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            call_req  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            emergency = ($urandom_range(0, 399) == 0);
`ifdef ELEV_OVERLOAD_EN
            if ($urandom_range(0, 9) == 0) overload = ~overload;
`endif
            tick();
        end
        emergency = 1'b0;
        call_req  = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_elevator_ctrl
`default_nettype wire

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter FLOORS, default 4, number of served floors, 2..16.
REQ-002 SHALL have parameter TRAVEL_CYC, default 8, clock cycles to move one floor, minimum 1.
REQ-003 SHALL have parameter DOOR_CYC, default 6, clock cycles the door stays open, minimum 1.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port emergency  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port call_req  input  FLOORS  per-floor call pulses; bit i requests floor i; any number of bits may be set together.
REQ-007 SHALL have port floor  output  $clog2(FLOORS)  current car floor.
REQ-008 SHALL have port dir_up  output  1  1 = up, 0 = down; current or last travel direction.
REQ-009 SHALL have port moving  output  1  high while in MOVING.
REQ-010 SHALL have port door_open  output  1  high while in DOOR_OPEN.
REQ-011 SHALL have port pending  output  FLOORS  latched outstanding requests.
REQ-012 SHALL have port arrived  output  1  one-cycle pulse on each floor-count change.

Function
REQ-013 SHALL use the three states IDLE, MOVING and DOOR_OPEN.
REQ-014 SHALL OR call_req into pending at each edge, visible the next cycle, except a bit for the current floor while in DOOR_OPEN.
REQ-015 SHALL, in IDLE with pending[floor] set, enter DOOR_OPEN next edge.
REQ-016 SHALL, in IDLE with no pending[floor], keep dir_up if any request lies ahead in it, else flip it, else stay IDLE with pending all zero.
REQ-017 SHALL, in IDLE, enter MOVING in the chosen direction and load the travel timer with TRAVEL_CYC.
REQ-018 SHALL, in MOVING, step floor by ±1 and pulse arrived when the travel timer expires, after exactly TRAVEL_CYC cycles per floor.
REQ-019 SHALL, on arrival at a pending floor, enter DOOR_OPEN on that same edge.
REQ-020 SHALL, on arrival at a non-pending floor, stay MOVING with timer reloaded if requests remain ahead, else go to IDLE.
REQ-021 SHALL never step floor below 0 or above FLOORS-1.
REQ-022 SHALL clear pending[floor] on entry to DOOR_OPEN and load the door timer with DOOR_CYC.
REQ-023 SHALL hold door_open for exactly DOOR_CYC cycles, then enter IDLE.
REQ-024 SHALL restart the door timer when call_req[floor] is set during DOOR_OPEN.
REQ-025 SHALL keep moving and door_open mutually exclusive, both low in IDLE.

Reset
REQ-026 SHALL, with emergency high at an edge, set floor=0, dir_up=1, pending=0, state IDLE, timers=0, and moving, door_open and arrived low, regardless of state.
REQ-027 SHALL ignore call_req on any edge where emergency is high.

Configuration
REQ-028 SHALL, with macro ELEV_OVERLOAD_EN defined, add input port overload (1 bit) that holds DOOR_OPEN and freezes the door timer while high.
REQ-029 SHALL, without ELEV_OVERLOAD_EN, omit the overload port and run the door timer unconditionally.

Structure
REQ-030 SHALL declare the state enum and the door/travel timer width constant in shared package elev_pkg.
REQ-031 SHALL implement the travel and door timers as one reusable sub-module elev_timer: load, decrement, expire pulse.

Verification
REQ-032 SHALL verify: reset, idle at floor 0, call_req=4'b0100 at cycle t -> moving from t+2; floor=1 at t+10; floor=2, door_open=1 at t+18; door_open=0 at t+24.
REQ-033 SHALL verify: idle at floor 2, call_req=4'b0100 -> door_open for 6 cycles with no movement and pending back to 0.
REQ-034 SHALL verify: at floor 1 moving up toward 3, call_req=4'b0001 -> stops at 3 first, then reverses with dir_up=0 and serves 0.
REQ-035 SHALL verify: call_req=4'b1111 at floor 0 -> floor 0 serviced immediately, then 1, 2, 3 in order, with 3 arrived pulses total.
REQ-036 SHALL verify: emergency asserted mid-travel between floors 2 and 3 -> next cycle floor=0, pending=0, moving=0, and calls during reset are not latched.
REQ-037 SHALL verify, with ELEV_OVERLOAD_EN defined: overload high for 10 cycles during DOOR_OPEN -> door_open held, and closing occurs only after the remaining door cycles once overload falls.
